// File: rtl/lsu_mem_port.sv
// lsu_mem_port: load/store unit between the core's execute stage and the shared
// memory request/response channels. Handles lane alignment, byte strobes,
// load sign/zero extension and misaligned-access errors.
// Optional build macro LSU_MISALIGN_SPLIT_EN: unaligned accesses of legal size
// are performed, and bus-word crossings are split into two beats.
module lsu_mem_port #(
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [31:0]           Address,
    output logic                  MemWrite,
    output logic                  MemRead,
    output logic [DATA_WIDTH-1:0] Write_data,
    output logic [STRB_WIDTH-1:0] Write_strb,
    input  logic                  Mem_Req_Ready,
    input  logic [DATA_WIDTH-1:0] Read_data,
    input  logic                  Read_data_Valid,
    output logic                  Read_data_Ready
);
    localparam int OFF_W = $clog2(STRB_WIDTH);

`ifdef LSU_MISALIGN_SPLIT_EN
    typedef enum logic [2:0] {IDLE, REQ, RESP, DONE, REQ1, RESP1} state_t;
`else
    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
`endif

    // Keep only the low (1<<size) bytes of d.
    function automatic logic [DATA_WIDTH-1:0] byte_keep(input logic [DATA_WIDTH-1:0] d,
                                                        input logic [1:0] size);
        logic [DATA_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < STRB_WIDTH; i++)
            if (i < (1 << size)) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // Truncate a lane-justified load to its size, then sign- or zero-extend.
    function automatic logic [DATA_WIDTH-1:0] extend_load(input logic [DATA_WIDTH-1:0] d,
                                                          input logic [1:0] size,
                                                          input logic uns);
        logic [DATA_WIDTH-1:0] r;
        logic                  s;
        r = byte_keep(d, size);
        case (size)
            2'd0:    s = d[7];
            2'd1:    s = d[15];
            2'd2:    s = d[31];
            default: s = 1'b0;
        endcase
        if (!uns)
            for (int i = 0; i < STRB_WIDTH; i++)
                if (i >= (1 << size)) r[8*i +: 8] = {8{s}};
        return r;
    endfunction

    state_t                state, state_nxt;
    logic                  wen_q, uns_q, err_q;
    logic [1:0]            size_q;
    logic [31:0]           addr_q;
    logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
    logic [OFF_W-1:0]      off_q;
    logic [OFF_W+2:0]      lane_sh;
    logic [31:0]           base_addr;
    logic [3:0]            nbytes;
    logic                  req_bad;

    assign off_q     = addr_q[OFF_W-1:0];
    assign lane_sh   = {off_q, 3'b000};
    assign base_addr = {addr_q[31:OFF_W], {OFF_W{1'b0}}};
    assign nbytes    = 4'd1 << size_q;

`ifdef LSU_MISALIGN_SPLIT_EN
    logic [2*STRB_WIDTH-1:0] strb_w;
    logic [2*DATA_WIDTH-1:0] data_w;
    logic [DATA_WIDTH-1:0]   lo_q, rd_split;
    logic                    cross;

    assign req_bad  = (req_size == 2'd3) && (DATA_WIDTH != 64);
    assign strb_w   = (2*STRB_WIDTH)'((32'd1 << nbytes) - 32'd1) << off_q;
    assign data_w   = {{DATA_WIDTH{1'b0}}, byte_keep(wdata_q, size_q)} << lane_sh;
    assign cross    = (32'(off_q) + 32'(nbytes)) > 32'(STRB_WIDTH);
    assign rd_split = DATA_WIDTH'({Read_data, lo_q} >> lane_sh);
`else
    logic [OFF_W-1:0]      off_in, size_mask;
    logic [STRB_WIDTH-1:0] strb_n;
    logic [DATA_WIDTH-1:0] data_n;

    assign off_in    = req_addr[OFF_W-1:0];
    assign size_mask = OFF_W'((32'd1 << req_size) - 32'd1);
    assign req_bad   = ((req_size == 2'd3) && (DATA_WIDTH != 64)) || (|(off_in & size_mask));
    assign strb_n    = STRB_WIDTH'((32'd1 << nbytes) - 32'd1) << off_q;
    assign data_n    = byte_keep(wdata_q, size_q) << lane_sh;
`endif

    // State register plus captured request and registered response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            wen_q   <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
            lo_q    <= '0;
`endif
        end else begin
            state <= state_nxt;
            if (state == IDLE && req_valid) begin
                wen_q   <= req_wen;
                uns_q   <= req_unsigned;
                size_q  <= req_size;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                err_q   <= req_bad;
                rdata_q <= '0;
            end
            if (state == RESP && Read_data_Valid) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                if (cross) lo_q <= Read_data;
                else       rdata_q <= extend_load(Read_data >> lane_sh, size_q, uns_q);
`else
                rdata_q <= extend_load(Read_data >> lane_sh, size_q, uns_q);
`endif
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            if (state == RESP1 && Read_data_Valid)
                rdata_q <= extend_load(rd_split, size_q, uns_q);
`endif
        end
    end

    // Next-state logic and state-decoded outputs; everything idles at 0.
    always_comb begin
        state_nxt       = state;
        req_ready       = 1'b0;
        resp_valid      = 1'b0;
        resp_rdata      = '0;
        resp_err        = 1'b0;
        Address         = '0;
        MemRead         = 1'b0;
        MemWrite        = 1'b0;
        Write_data      = '0;
        Write_strb      = '0;
        Read_data_Ready = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = req_bad ? DONE : REQ;
            end
            REQ: begin
                Address  = base_addr;
                MemRead  = ~wen_q;
                MemWrite = wen_q;
`ifdef LSU_MISALIGN_SPLIT_EN
                Write_data = data_w[DATA_WIDTH-1:0];
                Write_strb = strb_w[STRB_WIDTH-1:0];
                if (Mem_Req_Ready) state_nxt = (wen_q && cross) ? REQ1 : (wen_q ? DONE : RESP);
`else
                Write_data = data_n;
                Write_strb = strb_n;
                if (Mem_Req_Ready) state_nxt = wen_q ? DONE : RESP;
`endif
            end
            RESP: begin
                Read_data_Ready = 1'b1;
`ifdef LSU_MISALIGN_SPLIT_EN
                if (Read_data_Valid) state_nxt = cross ? REQ1 : DONE;
`else
                if (Read_data_Valid) state_nxt = DONE;
`endif
            end
            DONE: begin
                resp_valid = 1'b1;
                resp_rdata = rdata_q;
                resp_err   = err_q;
                if (resp_ready) state_nxt = IDLE;
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            REQ1: begin
                Address    = base_addr + 32'(STRB_WIDTH);
                MemRead    = ~wen_q;
                MemWrite   = wen_q;
                Write_data = data_w[2*DATA_WIDTH-1:DATA_WIDTH];
                Write_strb = strb_w[2*STRB_WIDTH-1:STRB_WIDTH];
                if (Mem_Req_Ready) state_nxt = wen_q ? DONE : RESP1;
            end
            RESP1: begin
                Read_data_Ready = 1'b1;
                if (Read_data_Valid) state_nxt = DONE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_lsu_mem_port.sv
// Testbench for lsu_mem_port (DATA_WIDTH=32, default build): directed cases
// plus randomized accesses against a byte-addressed memory reference model.
module tb_lsu_mem_port;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_wen, req_unsigned;
    logic [1:0]    req_size;
    logic [31:0]   req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid, resp_ready, resp_err;
    logic [DW-1:0] resp_rdata;
    logic [31:0]   Address;
    logic          MemWrite, MemRead;
    logic [DW-1:0] Write_data;
    logic [SW-1:0] Write_strb;
    logic          Mem_Req_Ready;
    logic [DW-1:0] Read_data;
    logic          Read_data_Valid, Read_data_Ready;

    always #5 clk = ~clk;

    lsu_mem_port #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .Address(Address), .MemWrite(MemWrite), .MemRead(MemRead),
        .Write_data(Write_data), .Write_strb(Write_strb),
        .Mem_Req_Ready(Mem_Req_Ready), .Read_data(Read_data),
        .Read_data_Valid(Read_data_Valid), .Read_data_Ready(Read_data_Ready)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] mem [0:63];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        int i;
        i = int'(a & 32'd60);
        return {mem[i+3], mem[i+2], mem[i+1], mem[i]};
    endfunction

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'(1));
        chk({tag, "_outs"}, 64'({resp_valid, resp_err, MemRead, MemWrite, Read_data_Ready}), 64'(0));
        chk({tag, "_buses"}, {Address, resp_rdata}, 64'(0));
        chk({tag, "_wbus"}, 64'({Write_strb, Write_data}), 64'(0));
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One complete access; starts and ends at a negedge with the DUT idle.
    task automatic do_access(input logic wen, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input int req_wait, input int rd_wait, input int resp_wait);
        int n, off, lat, hold, rdw, stall, cyc, exp_lat;
        logic bad, done;
        logic [31:0] exp_rd, exp_data;
        logic [3:0]  exp_strb;
        logic [63:0] v;
        n = 1 << size;
        off = int'(addr[1:0]);
        bad = (size == 2'd3) || ((off % n) != 0);
        exp_strb = '0;
        exp_data = '0;
        for (int k = 0; k < 4; k++)
            if (k >= off && k < off + n) begin
                exp_strb[k] = 1'b1;
                exp_data[8*k +: 8] = wdata[8*(k-off) +: 8];
            end
        v = '0;
        for (int k = 0; k < n && k < 4; k++)
            v = v | (64'(mem[int'((addr + 32'(k)) & 32'd63)]) << (8*k));
        if (!uns && n < 4 && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
        exp_rd = (wen || bad) ? 32'd0 : v[31:0];
        exp_lat = bad ? 1 : 2 + req_wait + (wen ? 0 : 1 + rd_wait);

        chk("idle_req_ready", 64'(req_ready), 64'(1));
        req_valid = 1'b1; req_wen = wen; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        // Inputs are ignored after capture; scramble them.
        req_valid = 1'($urandom % 2); req_wen = 1'($urandom % 2);
        req_size = 2'($urandom % 4); req_unsigned = 1'($urandom % 2);
        req_addr = $urandom; req_wdata = $urandom;

        lat = 0; hold = 0; rdw = 0; stall = 0; cyc = 0; done = 1'b0;
        while (!done && cyc < 200) begin
            cyc++;
            if (MemRead || MemWrite) begin
                chk("bus_addr", 64'(Address), 64'(addr & ~32'd3));
                chk("bus_rw", 64'({MemRead, MemWrite}), 64'({~wen, wen}));
                if (wen) begin
                    chk("wstrb", 64'(Write_strb), 64'(exp_strb));
                    chk("wdata", 64'(Write_data), 64'(exp_data));
                end
                Mem_Req_Ready = (hold == req_wait);
                hold++;
            end else Mem_Req_Ready = 1'($urandom % 2);
            if (Read_data_Ready) begin
                if (rdw == rd_wait) begin
                    Read_data_Valid = 1'b1;
                    Read_data = mem_word(addr);
                end else begin
                    Read_data_Valid = 1'b0;
                    Read_data = $urandom;
                end
                rdw++;
            end else begin
                Read_data_Valid = 1'($urandom % 2);
                Read_data = $urandom;
            end
            if (resp_valid) begin
                if (lat == 0) begin
                    lat = cyc;
                    chk("latency", 64'(lat), 64'(exp_lat));
                end
                chk("resp_rdata", 64'(resp_rdata), 64'(exp_rd));
                chk("resp_err", 64'(resp_err), 64'(bad));
                chk("done_req_ready", 64'(req_ready), 64'(0));
                if (stall >= resp_wait) begin
                    resp_ready = 1'b1;
                    req_valid = 1'b0;
                    done = 1'b1;
                end else resp_ready = 1'b0;
                stall++;
            end else resp_ready = 1'($urandom % 2);
            @(negedge clk);
        end
        resp_ready = 1'b0; Mem_Req_Ready = 1'b0; Read_data_Valid = 1'b0; req_valid = 1'b0;
        if (!done) begin
            chk("timeout", 64'(1), 64'(0));
            pulse_reset();
        end else begin
            chk("bus_cycles", 64'(hold), 64'(bad ? 0 : req_wait + 1));
            chk("rd_cycles", 64'(rdw), 64'((bad || wen) ? 0 : rd_wait + 1));
            chk("back_idle", 64'({req_ready, resp_valid, MemRead, MemWrite}), 64'(4'b1000));
            if (wen && !bad)
                for (int k = 0; k < n; k++)
                    mem[int'((addr + 32'(k)) & 32'd63)] = wdata[8*k +: 8];
        end
    endtask

    // Start an aligned load, then reset either in REQ or in RESP.
    task automatic reset_abort(input logic in_resp);
        req_valid = 1'b1; req_wen = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h0000_0040; req_wdata = $urandom;
        @(negedge clk);
        req_valid = 1'b0; Mem_Req_Ready = in_resp; Read_data_Valid = 1'b0;
        chk("abort_in_req", 64'(MemRead), 64'(1));
        if (in_resp) begin
            @(negedge clk);
            Mem_Req_Ready = 1'b0;
            chk("abort_in_resp", 64'(Read_data_Ready), 64'(1));
        end
        rst = 1'b1; Read_data_Valid = 1'b1; Read_data = $urandom;
        @(negedge clk);
        rst = 1'b0; Read_data_Valid = 1'b0;
        check_idle_outputs("abort");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_resp", 64'({resp_valid, req_ready}), 64'(2'b01));
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b0; Mem_Req_Ready = 1'b0;
        Read_data = '0; Read_data_Valid = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_idle_outputs("reset");

        // lw 0x104 -> 0xDEADBEEF
        mem[4] = 8'hEF; mem[5] = 8'hBE; mem[6] = 8'hAD; mem[7] = 8'hDE;
        do_access(1'b0, 2'd2, 1'b0, 32'h0000_0104, 32'd0, 0, 0, 0);
        // lb 0x203 from word 0x80112233, signed then unsigned
        mem[0] = 8'h33; mem[1] = 8'h22; mem[2] = 8'h11; mem[3] = 8'h80;
        do_access(1'b0, 2'd0, 1'b0, 32'h0000_0203, 32'd0, 0, 0, 0);
        do_access(1'b0, 2'd0, 1'b1, 32'h0000_0203, 32'd0, 0, 0, 0);
        // sh 0x302 with three stall cycles on the bus
        do_access(1'b1, 2'd1, 1'b0, 32'h0000_0302, 32'h0000_ABCD, 3, 0, 0);
        // misaligned word and illegal size
        do_access(1'b0, 2'd2, 1'b0, 32'h0000_0101, 32'd0, 0, 0, 0);
        do_access(1'b0, 2'd3, 1'b0, 32'h0000_0100, 32'd0, 0, 0, 0);
        // signed half load and response held for five cycles
        do_access(1'b0, 2'd1, 1'b0, 32'h0000_0302, 32'd0, 1, 2, 5);
        // reset mid-operation
        reset_abort(1'b1);
        reset_abort(1'b0);

        for (int t = 0; t < 60; t++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            sz = 2'($urandom_range(0, 3));
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~(32'(1 << sz) - 32'd1);
            do_access(1'($urandom % 2), sz, 1'($urandom % 2), a, $urandom,
                      $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
